// File: rtl/fmap_stream_reader.sv
// ---------------------------------------------------------------------------
// fmap_stream_reader
//
// Reads one pooled feature map out of a BRAM that stores it channel-major
// (addr = c*FM_HEIGHT*FM_WIDTH + h*FM_WIDTH + w) and streams it out in HWC
// order (c fastest, then w, then h) on a valid/ready interface.
//
// Reads are issued only when the prefetch FIFO is guaranteed to have room
// for the returning word, so returned data never needs to be dropped and the
// BRAM never needs to be stalled. With m_ready held high the stream runs at
// one beat per cycle.
//
// Ports
//   clk       clock
//   rst       asynchronous, active-high reset
//   start     begin one frame (ignored unless idle)
//   busy      frame in progress
//   done      one-cycle pulse the cycle after the final beat is accepted
//   mem_en    BRAM read enable
//   mem_addr  BRAM read address (valid together with mem_en)
//   mem_dout  BRAM read data, valid RD_LATENCY cycles after mem_en
//   m_valid   stream element valid
//   m_ready   downstream accept
//   m_data    stream element
//   m_last    final element of the frame
//
// The total read count CHANNELS*FM_HEIGHT*FM_WIDTH must fit in ADDR_WIDTH
// address bits.
// ---------------------------------------------------------------------------
module fmap_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 32,
   parameter int FM_HEIGHT  = 14,
   parameter int FM_WIDTH   = 16,
   parameter int ADDR_WIDTH = 13,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         mem_en,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic signed [DATA_WIDTH-1:0] mem_dout,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [DATA_WIDTH-1:0] m_data,
   output logic                         m_last
);

   localparam int CW    = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
   localparam int WW    = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
   localparam int HW    = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);
   localparam int PLANE = FM_HEIGHT * FM_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   // read-side position counters
   logic [CW-1:0] c_q;
   logic [WW-1:0] w_q;
   logic [HW-1:0] h_q;
   logic          c_wrap, w_wrap, h_wrap, last_rd;
   logic [31:0]   addr_full;

   // read latency tracking: bit k set means a read was issued k cycles ago
   logic [RD_LATENCY:1] vld_pipe;
   logic [RD_LATENCY:1] last_pipe;
   int                  inflight;
   logic                room;
   logic                issue;

   // prefetch FIFO
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [FCW-1:0]        fifo_count;
   logic                  fifo_wr;
   logic                  pop;
   logic                  done_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)           state_d = RUN;
         RUN:     if (issue && last_rd) state_d = DRAIN;
         DRAIN:   if (pop && m_last)    state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      busy   = 1'b0;
      mem_en = 1'b0;
      case (state_q)
         RUN: begin
            busy   = 1'b1;
            mem_en = room;
         end
         DRAIN:   busy = 1'b1;
         default: ;
      endcase
   end

   assign issue = mem_en;
   assign done  = done_q;

   // ------------------------------------------------------------------
   // Occupancy: words in the FIFO plus words still coming back from the
   // BRAM. Issuing only below FIFO_DEPTH means every returned word has a
   // slot waiting for it, whatever the downstream does meanwhile.
   // ------------------------------------------------------------------
   always_comb begin
      inflight = 0;
      for (int k = 1; k <= RD_LATENCY; k++)
         inflight = inflight + int'(vld_pipe[k]);
   end

   assign room = (int'(fifo_count) + inflight) < FIFO_DEPTH;

   // ------------------------------------------------------------------
   // Read counters, c innermost so the BRAM is walked in HWC order
   // ------------------------------------------------------------------
   assign c_wrap  = (c_q == CW'(CHANNELS - 1));
   assign w_wrap  = (w_q == WW'(FM_WIDTH - 1));
   assign h_wrap  = (h_q == HW'(FM_HEIGHT - 1));
   assign last_rd = c_wrap & w_wrap & h_wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q <= '0;
         w_q <= '0;
         h_q <= '0;
      end else if (state_q == IDLE && start) begin
         c_q <= '0;
         w_q <= '0;
         h_q <= '0;
      end else if (issue) begin
         if (c_wrap) begin
            c_q <= '0;
            if (w_wrap) begin
               w_q <= '0;
               h_q <= h_wrap ? '0 : h_q + 1'b1;
            end else begin
               w_q <= w_q + 1'b1;
            end
         end else begin
            c_q <= c_q + 1'b1;
         end
      end
   end

   // channel-major address, formed at 32 bits and truncated to the port
   assign addr_full = 32'(c_q) * 32'(PLANE) + 32'(h_q) * 32'(FM_WIDTH) + 32'(w_q);
   assign mem_addr  = addr_full[ADDR_WIDTH-1:0];

   // ------------------------------------------------------------------
   // Read latency shift register; the last flag travels with its read
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe[1]  <= issue;
         last_pipe[1] <= issue & last_rd;
         for (int k = 2; k <= RD_LATENCY; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            last_pipe[k] <= last_pipe[k-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Prefetch FIFO
   // ------------------------------------------------------------------
   assign fifo_wr = vld_pipe[RD_LATENCY];
   assign m_valid = (fifo_count != '0);
   assign pop     = m_valid & m_ready;

   // storage needs no reset: nothing is visible until fifo_count says so
   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_data[wr_ptr] <= mem_dout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         fifo_last  <= '0;
      end else begin
         if (fifo_wr) begin
            fifo_last[wr_ptr] <= last_pipe[RD_LATENCY];
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({fifo_wr, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // outputs are forced to zero when empty so reset shows clean zeros
   assign m_data = m_valid ? fifo_data[rd_ptr] : '0;
   assign m_last = m_valid & fifo_last[rd_ptr];

   // done lands the cycle after the final beat transfers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= pop & m_last;
   end

endmodule
